// File: rtl/mc6801_sci.sv
// mc6801_sci: MC6801 serial communications interface, register window $0010-$0013.
// 8N1 transmitter and receiver timed from clk with a 16/128/1024/4096 clk bit period.
module mc6801_sci (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] ADDRESS,
  input  logic [7:0]  DATA_OUT,
  input  logic        rw,
  input  logic        E_CLK,
  output logic        sci_sel,
  output logic [7:0]  sci_rdata,
  output logic        irq_sci,
  input  logic        RXD,
  output logic        TXD,
  output logic        tx_en
);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_e;

  logic [1:0]  cc_q, cc_d, ss_q, ss_d;
  logic        rdrf_q, rdrf_d, orfe_q, orfe_d, tdre_q, tdre_d;
  logic        rie_q, rie_d, re_q, re_d, tie_q, tie_d, te_q, te_d, wu_q, wu_d;
  logic [7:0]  rdr_q, rdr_d, tdr_q, tdr_d;
  logic        rx_arm_q, rx_arm_d, tx_arm_q, tx_arm_d;
  logic        irq_q;
  logic        rx_meta_q, rxs_q, rxs_prev_q;

  ser_state_e  tx_state_q, tx_state_d;
  logic [12:0] tx_cnt_q, tx_cnt_d, tx_per_q, tx_per_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d, tx_load;

  ser_state_e  rx_state_q, rx_state_d;
  logic [12:0] rx_cnt_q, rx_cnt_d, rx_per_q, rx_per_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done;

  logic [12:0] idle_tick_q, idle_tick_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;

  logic [12:0] period;
  logic        rd_en, wr_en, rd_trcsr, rd_rdr, wr_rmcr, wr_trcsr, wr_tdr;

  assign sci_sel  = (ADDRESS[15:2] == 14'h0004);
  assign rd_en    = E_CLK & rw;
  assign wr_en    = E_CLK & ~rw;
  assign rd_trcsr = rd_en & (ADDRESS == 16'h0011);
  assign rd_rdr   = rd_en & (ADDRESS == 16'h0012);
  assign wr_rmcr  = wr_en & (ADDRESS == 16'h0010);
  assign wr_trcsr = wr_en & (ADDRESS == 16'h0011);
  assign wr_tdr   = wr_en & (ADDRESS == 16'h0013);

  assign irq_sci = irq_q;
  assign TXD     = txd_q;
  assign tx_en   = te_q;

  always_comb begin
    case (ss_q)
      2'd0:    period = 13'd16;
      2'd1:    period = 13'd128;
      2'd2:    period = 13'd1024;
      default: period = 13'd4096;
    endcase
  end

  always_comb begin
    case (ADDRESS[1:0])
      2'd0:    sci_rdata = {4'hF, cc_q, ss_q};
      2'd1:    sci_rdata = {rdrf_q, orfe_q, tdre_q, rie_q, re_q, tie_q, te_q, wu_q};
      2'd2:    sci_rdata = rdr_q;
      default: sci_rdata = 8'hFF;
    endcase
  end

  // Transmitter: the period is re-latched at every bit boundary so SS changes apply per bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_per_d   = tx_per_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    if (tx_state_q == ST_IDLE) begin
      txd_d   = 1'b1;
      tx_load = te_q & ~tdre_q;
    end else if (tx_cnt_q == tx_per_q - 13'd1) begin
      tx_cnt_d = '0;
      tx_per_d = period;
      case (tx_state_q)
        ST_START: begin
          tx_state_d = ST_DATA;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
        end
        ST_DATA: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[7:1]};
          end
        end
        default: begin
          tx_state_d = ST_IDLE;
          tx_load    = te_q & ~tdre_q;
        end
      endcase
    end else begin
      tx_cnt_d = tx_cnt_q + 13'd1;
    end
    if (tx_load) begin
      tx_state_d = ST_START;
      txd_d      = 1'b0;
      tx_shift_d = tdr_q;
      tx_cnt_d   = '0;
      tx_per_d   = period;
    end
  end

  // Receiver: rx_cnt_q holds the clk index since the last sample point (start edge = 0).
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_per_d   = rx_per_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rxs_prev_q & ~rxs_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = 13'd1;
          rx_per_d   = period;
        end
      end
      ST_START: begin
        if (rx_cnt_q == {1'b0, rx_per_q[12:1]}) begin
          if (rxs_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
            rx_cnt_d   = 13'd1;
            rx_per_d   = period;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 13'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == rx_per_q) begin
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          rx_cnt_d   = 13'd1;
          rx_per_d   = period;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 13'd1;
        end
      end
      default: begin
        if (rx_cnt_q == rx_per_q) begin
          rx_state_d = ST_IDLE;
          rx_done    = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 13'd1;
        end
      end
    endcase
    if (!re_q) begin
      rx_state_d = ST_IDLE;
      rx_done    = 1'b0;
    end
  end

  always_comb begin
    idle_tick_d = idle_tick_q;
    idle_cnt_d  = idle_cnt_q;
    if (!(re_q && wu_q) || !rxs_q) begin
      idle_tick_d = '0;
      idle_cnt_d  = '0;
    end else if (idle_tick_q == period - 13'd1) begin
      idle_tick_d = '0;
      if (idle_cnt_q != 4'd10) idle_cnt_d = idle_cnt_q + 4'd1;
    end else begin
      idle_tick_d = idle_tick_q + 13'd1;
    end
  end

  always_comb begin
    cc_d     = cc_q;
    ss_d     = ss_q;
    rie_d    = rie_q;
    re_d     = re_q;
    tie_d    = tie_q;
    te_d     = te_q;
    wu_d     = wu_q;
    tdr_d    = tdr_q;
    rdr_d    = rdr_q;
    rdrf_d   = rdrf_q;
    orfe_d   = orfe_q;
    tdre_d   = tdre_q;
    rx_arm_d = rx_arm_q;
    tx_arm_d = tx_arm_q;
    if (wr_rmcr) {cc_d, ss_d} = DATA_OUT[3:0];
    if (wr_trcsr) {rie_d, re_d, tie_d, te_d, wu_d} = DATA_OUT[4:0];
    if (wr_tdr) tdr_d = DATA_OUT;
    if (rd_trcsr && (rdrf_q || orfe_q)) rx_arm_d = 1'b1;
    if (rd_rdr && rx_arm_q) begin
      rdrf_d   = 1'b0;
      orfe_d   = 1'b0;
      rx_arm_d = 1'b0;
    end
    if (rd_trcsr && tdre_q) tx_arm_d = 1'b1;
    if (wr_tdr && tx_arm_q) begin
      tdre_d   = 1'b0;
      tx_arm_d = 1'b0;
    end
    // Hardware updates come last so a same-cycle flag set beats a software clear.
    if (rx_done && !wu_q) begin
      if (!rxs_q) begin
        orfe_d = 1'b1;
        rdr_d  = rx_shift_q;
      end else if (rdrf_q) begin
        orfe_d = 1'b1;
      end else begin
        rdrf_d = 1'b1;
        rdr_d  = rx_shift_q;
      end
    end
    if (tx_load) tdre_d = 1'b1;
    if (idle_cnt_q == 4'd10) wu_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      cc_q <= '0;  ss_q <= '0;
      rdrf_q <= 1'b0;  orfe_q <= 1'b0;  tdre_q <= 1'b1;
      rie_q <= 1'b0;  re_q <= 1'b0;  tie_q <= 1'b0;  te_q <= 1'b0;  wu_q <= 1'b0;
      rdr_q <= '0;  tdr_q <= '0;
      rx_arm_q <= 1'b0;  tx_arm_q <= 1'b0;
      irq_q <= 1'b0;
      rx_meta_q <= 1'b1;  rxs_q <= 1'b1;  rxs_prev_q <= 1'b1;
      tx_state_q <= ST_IDLE;  tx_cnt_q <= '0;  tx_per_q <= 13'd16;
      tx_bit_q <= '0;  tx_shift_q <= '0;  txd_q <= 1'b1;
      rx_state_q <= ST_IDLE;  rx_cnt_q <= '0;  rx_per_q <= 13'd16;
      rx_bit_q <= '0;  rx_shift_q <= '0;
      idle_tick_q <= '0;  idle_cnt_q <= '0;
    end else begin
      cc_q <= cc_d;  ss_q <= ss_d;
      rdrf_q <= rdrf_d;  orfe_q <= orfe_d;  tdre_q <= tdre_d;
      rie_q <= rie_d;  re_q <= re_d;  tie_q <= tie_d;  te_q <= te_d;  wu_q <= wu_d;
      rdr_q <= rdr_d;  tdr_q <= tdr_d;
      rx_arm_q <= rx_arm_d;  tx_arm_q <= tx_arm_d;
      irq_q <= (rie_q & (rdrf_q | orfe_q)) | (tie_q & tdre_q);
      rx_meta_q <= RXD;  rxs_q <= rx_meta_q;  rxs_prev_q <= rxs_q;
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_per_q <= tx_per_d;
      tx_bit_q <= tx_bit_d;  tx_shift_q <= tx_shift_d;  txd_q <= txd_d;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_per_q <= rx_per_d;
      rx_bit_q <= rx_bit_d;  rx_shift_q <= rx_shift_d;
      idle_tick_q <= idle_tick_d;  idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule
